mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_if.sv | 33 +++
 rtl/mul_arbiter.sv | 120 ++++++++++++
 tb/tb_mul_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_arbiter_if.sv
// Handshake bundle for the shared 8x8 signed multiplier arbiter.
// Two requesters feed one result channel; busy mirrors FSM activity.
interface mul_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_x;
  logic [7:0] req0_y;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_x;
  logic [7:0] req1_y;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [15:0] rsp_p;
  logic       busy;

  modport slave (
    input  req0_valid, req0_x, req0_y,
    input  req1_valid, req1_x, req1_y,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_p, busy
  );

  modport master (
    output req0_valid, req0_x, req0_y,
    output req1_valid, req1_x, req1_y,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_p, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// Two-requester arbiter around one signed 8x8 multiplier (IDLE/MUL/HOLD).
// Define MUL_FIXED_PRIO_EN for fixed req0 priority instead of round-robin.
module mul_arbiter #(
  parameter int unsigned SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [7:0]        r_x;
  logic [7:0]        r_y;
  logic              r_id;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [15:0]       r_rsp_p;

  logic              w_idle;
  logic              w_grant;
  logic              w_rdy0;
  logic              w_rdy1;
  logic              w_hs;
  logic signed [15:0] w_xs;
  logic signed [15:0] w_ys;
  logic signed [15:0] w_prod;

`ifndef MUL_FIXED_PRIO_EN
  logic              r_last;
`endif

  // ready is gated by rst_n so nothing is offered while reset is held
  assign w_idle = rst_n && (r_state == S_IDLE);

  always_comb begin
    w_grant = 1'b0;
`ifdef MUL_FIXED_PRIO_EN
    if (bus.req0_valid)
      w_grant = 1'b0;
    else if (bus.req1_valid)
      w_grant = 1'b1;
`else
    if (bus.req0_valid && bus.req1_valid)
      w_grant = ~r_last;
    else if (bus.req1_valid)
      w_grant = 1'b1;
`endif
  end

  assign w_rdy0 = w_idle && !w_grant && bus.req0_valid;
  assign w_rdy1 = w_idle &&  w_grant && bus.req1_valid;
  assign w_hs   = w_rdy0 || w_rdy1;

  assign w_xs   = $signed({{8{r_x[7]}}, r_x});
  assign w_ys   = $signed({{8{r_y[7]}}, r_y});
  assign w_prod = w_xs * w_ys;

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_p      = r_rsp_p;
  assign bus.busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_x         <= 8'd0;
      r_y         <= 8'd0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_p     <= 16'd0;
`ifndef MUL_FIXED_PRIO_EN
      r_last      <= 1'b1;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_x     <= w_grant ? bus.req1_x : bus.req0_x;
            r_y     <= w_grant ? bus.req1_y : bus.req0_y;
            r_id    <= w_grant;
            r_cnt   <= 4'(SETTLE - 1);
            r_state <= S_MUL;
`ifndef MUL_FIXED_PRIO_EN
            r_last  <= w_grant;
`endif
          end
        end
        S_MUL: begin
          if (r_cnt == 4'd0) begin
            r_rsp_p     <= w_prod;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_state     <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: SETTLE=2 main unit plus SETTLE=1/15 units.
// Honours MUL_FIXED_PRIO_EN when computing the expected tie grants.
module tb_mul_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  mul_arbiter_if bus ();
  mul_arbiter_if bus1 ();
  mul_arbiter_if bus15 ();

  mul_arbiter #(.SETTLE(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mul_arbiter #(.SETTLE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  mul_arbiter #(.SETTLE(15)) u_dut15 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic op(input bit who, input logic [7:0] x,
                    input logic [7:0] y, input logic [15:0] exp_p,
                    input int exp_lat);
    int n;
    @(negedge clk);
    if (who) begin
      bus.req1_valid = 1'b1;
      bus.req1_x     = x;
      bus.req1_y     = y;
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_x     = x;
      bus.req0_y     = y;
    end
    #1;
    chk("op_rdy", who ? bus.req1_ready : bus.req0_ready, 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("op_lat", n, exp_lat);
    chk("op_p", bus.rsp_p, exp_p);
    chk("op_id", bus.rsp_id, who);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("op_drain", bus.rsp_valid, 0);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int ids[4];
    logic [15:0] ps[4];
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.req0_valid = 0; bus.req0_x = 0; bus.req0_y = 0;
    bus.req1_valid = 0; bus.req1_x = 0; bus.req1_y = 0;
    bus.rsp_ready  = 0;
    bus1.req0_valid = 0; bus1.req0_x = 0; bus1.req0_y = 0;
    bus1.req1_valid = 0; bus1.req1_x = 0; bus1.req1_y = 0;
    bus1.rsp_ready  = 0;
    bus15.req0_valid = 0; bus15.req0_x = 0; bus15.req0_y = 0;
    bus15.req1_valid = 0; bus15.req1_x = 0; bus15.req1_y = 0;
    bus15.rsp_ready  = 0;

    // reset state, with a request pending that must not be offered ready
    repeat (3) @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_p", bus.rsp_p, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdy0", bus.req0_ready, 0);
    chk("rst_rdy1", bus.req1_ready, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst_n = 1'b1;

    // 5 * -3 = -15
    op(0, 8'h05, 8'hFD, 16'hFFF1, 3);
    op(0, 8'h80, 8'h80, 16'h4000, 3);
    op(1, 8'h80, 8'h7F, 16'hC080, 3);
    op(0, 8'h7F, 8'h7F, 16'h3F01, 3);

    // result held while the consumer stalls; req1 locked out meanwhile
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_x = 8'h10;
    bus.req0_y = 8'h10;
    #1;
    chk("hold_rdy0", bus.req0_ready, 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_x = 8'h01;
    bus.req1_y = 8'h01;
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      chk("mul_rdy1", bus.req1_ready, 0);
      @(negedge clk);
      n++;
    end
    chk("hold_lat", n, 3);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_p", bus.rsp_p, 16'h0100);
      chk("hold_id", bus.rsp_id, 0);
      chk("hold_busy", bus.busy, 1);
      chk("hold_rdy1", bus.req1_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_valid", bus.rsp_valid, 0);
    chk("rel_rdy1", bus.req1_ready, 1);
    // req1 withdraws with no handshake; rsp_ready stays high while idle
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("drop_busy", bus.busy, 0);
    chk("idle_rr_valid", bus.rsp_valid, 0);
    chk("idle_rr_p", bus.rsp_p, 16'h0100);
    bus.rsp_ready = 1'b0;

    // SETTLE=1: 3 * -3 = -9
    @(negedge clk);
    bus1.req0_valid = 1'b1;
    bus1.req0_x = 8'h03;
    bus1.req0_y = 8'hFD;
    #1;
    chk("s1_rdy", bus1.req0_ready, 1);
    @(negedge clk);
    bus1.req0_valid = 1'b0;
    n = 1;
    while (!bus1.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("s1_lat", n, 2);
    chk("s1_p", bus1.rsp_p, 16'hFFF7);
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;

    // SETTLE=15: -7 * 9 = -63
    bus15.req1_valid = 1'b1;
    bus15.req1_x = 8'hF9;
    bus15.req1_y = 8'h09;
    #1;
    chk("s15_rdy", bus15.req1_ready, 1);
    @(negedge clk);
    bus15.req1_valid = 1'b0;
    n = 1;
    while (!bus15.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("s15_lat", n, 16);
    chk("s15_p", bus15.rsp_p, 16'hFFC1);
    chk("s15_id", bus15.rsp_id, 1);
    bus15.rsp_ready = 1'b1;
    @(negedge clk);
    bus15.rsp_ready = 1'b0;

    // reset pulse in MUL discards the operation (last grant was req0)
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_x = 8'h07;
    bus.req0_y = 8'h07;
    @(negedge clk);
    chk("abort_busy_pre", bus.busy, 1);
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_valid", bus.rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("abort_never", seen, 0);

    // both requesters held valid, consumer always ready
    bus.req0_x = 8'h03;
    bus.req0_y = 8'h04;
    bus.req1_x = 8'hFE;
    bus.req1_y = 8'h05;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp_ready  = 1'b1;
    #1;
    chk("tie_rdy0", bus.req0_ready, 1);
    chk("tie_rdy1", bus.req1_ready, 0);
    seen = 0;
    n = 0;
    while (seen < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.rsp_valid) begin
        ids[seen] = int'(bus.rsp_id);
        ps[seen]  = bus.rsp_p;
        seen++;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("tie_count", seen, 4);
    for (int k = 0; k < 4; k++) begin
`ifdef MUL_FIXED_PRIO_EN
      chk("tie_id", ids[k], 0);
      chk("tie_p", ps[k], 16'h000C);
`else
      chk("tie_id", ids[k], k % 2);
      chk("tie_p", ps[k], (k % 2) ? 16'hFFF6 : 16'h000C);
`endif
    end
    repeat (2) @(negedge clk);
    chk("end_busy", bus.busy, 0);
    bus.rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
